// File: rtl/conv_output_reorder_if.sv
// Pixel-major output stream of the conv output reorder buffer.
// Plain valid/ready handshake with an end-of-frame marker.
interface conv_output_reorder_if #(
    parameter int N  = 16,
    parameter int CW = 4
);
    logic [N-1:0]  out_data;
    logic [CW-1:0] out_channel;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    modport master (
        output out_data,
        output out_channel,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_channel,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/conv_output_reorder.sv
// Captures one channel-major convolver frame into block RAM and
// replays it pixel-major through a 2-entry skid buffer.
module conv_output_reorder #(
    parameter int N        = 16,
    parameter int OUT_SIZE = 112,
    parameter int CHANNELS = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [N-1:0]                in_data,
    input  logic [$clog2(CHANNELS)-1:0] in_channel,
    input  logic                        in_valid,
    conv_output_reorder_if.master       out,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        error
);
    localparam int P     = OUT_SIZE * OUT_SIZE;
    localparam int TOTAL = P * CHANNELS;
    localparam int CW    = $clog2(CHANNELS);
    localparam int PW    = $clog2(P);
    localparam int AW    = $clog2(TOTAL);
    localparam int EW    = N + CW + 1;

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t        state, state_d;
    logic [PW-1:0] wr_pix, rd_pix;
    logic [CW-1:0] exp_ch, rd_ch, rd_ch_q;
    logic          rd_all, rd_pend, rd_last_q;
    logic [N-1:0]  rd_q;
    logic [N-1:0]  mem [TOTAL];
    logic [1:0]    occ, credit;
    logic [EW-1:0] sk0, sk1, push_word;
    logic          wr_en, wr_last, rd_en, rd_last, pop;
    logic [AW-1:0] wr_addr, rd_addr;

    assign wr_en   = (state == FILL) && in_valid;
    assign wr_last = (exp_ch == CW'(CHANNELS - 1)) && (wr_pix == PW'(P - 1));
    assign wr_addr = AW'(in_channel) * AW'(P) + AW'(wr_pix);
    assign rd_last = (rd_ch == CW'(CHANNELS - 1)) && (rd_pix == PW'(P - 1));
    assign rd_addr = AW'(rd_ch) * AW'(P) + AW'(rd_pix);

    // Count this cycle's pop as freed space so a full stream sustains 1 word/cycle.
    assign pop    = out.out_valid && out.out_ready;
    assign credit = occ + {1'b0, rd_pend} - {1'b0, pop};
    assign rd_en  = (state == DRAIN) && !rd_all && (credit < 2'd2);

    assign push_word       = {rd_last_q, rd_ch_q, rd_q};
    assign out.out_valid   = (occ != 2'd0);
    assign out.out_data    = sk0[N-1:0];
    assign out.out_channel = sk0[N +: CW];
    assign out.out_last    = sk0[EW-1] && out.out_valid;
    assign busy            = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start) state_d = FILL;
            FILL:    if (wr_en && wr_last) state_d = DRAIN;
            DRAIN:   if (pop && out.out_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= in_data;
        if (rd_en) rd_q <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_pix     <= '0;
            exp_ch     <= '0;
            rd_pix     <= '0;
            rd_ch      <= '0;
            rd_ch_q    <= '0;
            rd_all     <= 1'b0;
            rd_pend    <= 1'b0;
            rd_last_q  <= 1'b0;
            error      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state == DRAIN) && pop && out.out_last;
            rd_pend    <= rd_en;
            if ((state == IDLE) && start) begin
                error  <= 1'b0;
                wr_pix <= '0;
                exp_ch <= '0;
                rd_pix <= '0;
                rd_ch  <= '0;
                rd_all <= 1'b0;
            end
            if (wr_en) begin
                if (in_channel != exp_ch) error <= 1'b1;
                if (wr_pix == PW'(P - 1)) begin
                    wr_pix <= '0;
                    exp_ch <= exp_ch + CW'(1);
                end else begin
                    wr_pix <= wr_pix + PW'(1);
                end
            end
            if ((state == DRAIN) && in_valid) error <= 1'b1;
            if (rd_en) begin
                rd_ch_q   <= rd_ch;
                rd_last_q <= rd_last;
                if (rd_last) rd_all <= 1'b1;
                if (rd_ch == CW'(CHANNELS - 1)) begin
                    rd_ch  <= '0;
                    rd_pix <= rd_pix + PW'(1);
                end else begin
                    rd_ch <= rd_ch + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ <= 2'd0;
            sk0 <= '0;
            sk1 <= '0;
        end else begin
            unique case ({rd_pend, pop})
                2'b10: begin
                    if (occ == 2'd0) sk0 <= push_word;
                    else             sk1 <= push_word;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    sk0 <= sk1;
                    occ <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        sk0 <= push_word;
                    end else begin
                        sk0 <= sk1;
                        sk1 <= push_word;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_output_reorder.sv
// Bench for conv_output_reorder: small 4x4x2 frame, random data,
// reference memory indexed by (tag channel, pixel) read back pixel-major.
module tb_conv_output_reorder;
    localparam int N        = 16;
    localparam int OUT_SIZE = 4;
    localparam int CH       = 2;
    localparam int P        = OUT_SIZE * OUT_SIZE;
    localparam int TOTAL    = P * CH;
    localparam int CW       = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [N-1:0]  in_data;
    logic [CW-1:0] in_channel;
    logic          busy, frame_done, error;

    int checks = 0;
    int errors = 0;

    logic [N-1:0] frame [CH][P];
    logic [N-1:0] mdl   [CH][P];

    conv_output_reorder_if #(.N(N), .CW(CW)) ob ();

    conv_output_reorder #(
        .N(N),
        .OUT_SIZE(OUT_SIZE),
        .CHANNELS(CH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .in_data(in_data),
        .in_channel(in_channel),
        .in_valid(in_valid),
        .out(ob),
        .busy(busy),
        .frame_done(frame_done),
        .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input bit rnd);
        for (int c = 0; c < CH; c++)
            for (int p = 0; p < P; p++)
                frame[c][p] = rnd ? N'($urandom) : N'((c << 8) | p);
    endtask

    // Words go out channel-major; bad_k retags one word; stop_after cuts the frame short.
    task automatic send_frame(input int gap, input int bad_k, input bit start_mid,
                              input bit start_with_valid, input int stop_after);
        int c, p, tag;
        start      = 1'b1;
        in_valid   = start_with_valid;
        in_data    = N'($urandom);
        in_channel = CW'(1);
        step();
        start    = 1'b0;
        in_valid = 1'b0;
        chk("busy_after_start", 32'(busy), 32'(1));
        chk("error_after_start", 32'(error), 32'(0));
        for (int k = 0; k < TOTAL; k++) begin
            if (stop_after >= 0 && k == stop_after) return;
            c   = k / P;
            p   = k % P;
            tag = (k == bad_k) ? (c ^ 1) : c;
            in_valid   = 1'b1;
            in_data    = frame[c][p];
            in_channel = CW'(tag);
            mdl[tag][p] = frame[c][p];
            step();
            in_valid = 1'b0;
            if (k != TOTAL - 1) begin
                for (int g = 0; g < gap; g++) begin
                    if (start_mid && k == 3 && g == 1) start = 1'b1;
                    step();
                    start = 1'b0;
                end
            end
        end
    endtask

    // Entered on DRAIN cycle 0; word n must be channel n%CH of pixel n/CH.
    task automatic drain(input int pct, input int stall_at, input bit inject, input bit chk_lat);
        int n = 0, cyc = 0, first_v = -1, last_cyc = -1, stall_left = 0;
        int c, p;
        bit held = 0, stall_used = 0;
        logic [N-1:0] hd;
        logic [CW-1:0] hc;
        logic hl;
        while (n < TOTAL && cyc < 3000) begin
            if (held) begin
                chk("hold_valid", 32'(ob.out_valid), 32'(1));
                chk("hold_data", 32'(ob.out_data), 32'(hd));
                chk("hold_chan", 32'(ob.out_channel), 32'(hc));
                chk("hold_last", 32'(ob.out_last), 32'(hl));
            end
            if (stall_at >= 0 && !stall_used && n == stall_at) begin
                stall_used = 1;
                stall_left = 10;
            end
            if (stall_left > 0) begin
                ob.out_ready = 1'b0;
                stall_left--;
            end else begin
                ob.out_ready = ($urandom_range(99) < pct);
            end
            in_valid   = inject && (cyc == 4);
            in_data    = N'($urandom);
            in_channel = '0;
            chk("busy_drain", 32'(busy), 32'(1));
            if (ob.out_valid && first_v < 0) first_v = cyc;
            if (ob.out_valid && ob.out_ready) begin
                p = n / CH;
                c = n % CH;
                chk("data", 32'(ob.out_data), 32'(mdl[c][p]));
                chk("chan", 32'(ob.out_channel), 32'(c));
                chk("last", 32'(ob.out_last), 32'(n == TOTAL - 1));
                n++;
                if (n == TOTAL) last_cyc = cyc;
                held = 0;
            end else begin
                held = ob.out_valid;
                hd   = ob.out_data;
                hc   = ob.out_channel;
                hl   = ob.out_last;
            end
            step();
            cyc++;
        end
        in_valid     = 1'b0;
        ob.out_ready = 1'b1;
        chk("word_count", 32'(n), 32'(TOTAL));
        if (chk_lat) begin
            chk("first_valid_latency", 32'(first_v), 32'(2));
            chk("burst_end", 32'(last_cyc), 32'(first_v + TOTAL - 1));
        end
        chk("frame_done_pulse", 32'(frame_done), 32'(1));
        chk("busy_end", 32'(busy), 32'(0));
        chk("valid_end", 32'(ob.out_valid), 32'(0));
        for (int i = 0; i < 4; i++) begin
            step();
            chk("frame_done_once", 32'(frame_done), 32'(0));
            chk("valid_quiet", 32'(ob.out_valid), 32'(0));
        end
    endtask

    initial begin
        rst          = 1'b0;
        start        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_channel   = '0;
        ob.out_ready = 1'b0;
        repeat (3) step();
        chk("rst_valid", 32'(ob.out_valid), 32'(0));
        chk("rst_data", 32'(ob.out_data), 32'(0));
        chk("rst_chan", 32'(ob.out_channel), 32'(0));
        chk("rst_last", 32'(ob.out_last), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(frame_done), 32'(0));
        chk("rst_error", 32'(error), 32'(0));
        rst = 1'b1;
        step();

        // basic reorder, latency and throughput
        fill(0);
        send_frame(0, -1, 0, 0, -1);
        chk("s1_error_fill", 32'(error), 32'(0));
        drain(100, -1, 0, 1);
        chk("s1_error_end", 32'(error), 32'(0));

        // backpressure with a 10-cycle stall
        fill(1);
        send_frame(0, -1, 0, 0, -1);
        drain(30, 12, 0, 0);

        // misstagged word
        fill(1);
        send_frame(0, 5, 0, 0, -1);
        chk("s4_error_tag", 32'(error), 32'(1));
        drain(100, -1, 0, 1);
        chk("s4_error_sticky", 32'(error), 32'(1));

        // input during drain
        fill(1);
        send_frame(0, -1, 0, 0, -1);
        chk("s4_error_clean", 32'(error), 32'(0));
        drain(100, -1, 1, 1);
        chk("s4_error_drain_in", 32'(error), 32'(1));

        // reset mid-frame
        fill(1);
        send_frame(0, -1, 0, 0, 20);
        rst = 1'b0;
        #1;
        chk("s5_valid", 32'(ob.out_valid), 32'(0));
        chk("s5_data", 32'(ob.out_data), 32'(0));
        chk("s5_last", 32'(ob.out_last), 32'(0));
        chk("s5_busy", 32'(busy), 32'(0));
        chk("s5_error", 32'(error), 32'(0));
        chk("s5_done", 32'(frame_done), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) begin
            step();
            chk("s5_no_done", 32'(frame_done), 32'(0));
            chk("s5_idle", 32'(busy), 32'(0));
        end
        fill(1);
        send_frame(0, -1, 0, 0, -1);
        drain(70, -1, 0, 0);

        // gappy input, stray start, start with in_valid
        fill(0);
        send_frame(3, -1, 1, 1, -1);
        chk("s6_error", 32'(error), 32'(0));
        drain(100, -1, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_output_reorder.md
Name: conv_output_reorder

Overview:
- Receiver for the first-layer convolver's output stream (conv_out / channel_out / valid_out / done).
- The convolver emits results channel-major: every pixel of channel 0, then every pixel of channel 1, and so on.
- This block buffers one full output frame, then streams it back pixel-major (all channels of pixel 0, then pixel 1, ...) over a valid/ready interface.
- Pixel-major order is what the following batch-norm/h-swish and depthwise stages consume.

Parameters:
- N, 16, data word width (Q8.8 fixed point, passed through unmodified)
- OUT_SIZE, 112, output feature-map side length; P = OUT_SIZE*OUT_SIZE pixels per channel
- CHANNELS, 16, number of output channels; TOTAL = P*CHANNELS words per frame

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock domain; asynchronous, active-low
- start  in  1  single-cycle pulse; arms capture of a new frame (honoured in IDLE only)
- in_data  in  N  convolver result word
- in_channel  in  $clog2(CHANNELS)  channel tag of in_data
- in_valid  in  1  in_data/in_channel valid this cycle (no backpressure toward the convolver)
- out_data  out  N  reordered word
- out_channel  out  $clog2(CHANNELS)  channel of out_data
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts the word
- out_last  out  1  high with the final word of the frame (channel CHANNELS-1 of pixel P-1)
- busy  out  1  high in FILL and DRAIN
- frame_done  out  1  one-cycle pulse after the last word is accepted
- error  out  1  sticky protocol-error flag, cleared by start

Behaviour:
- Reset (asynchronous, rst low): state IDLE; all counters 0.
  - out_data, out_channel, out_valid, out_last, busy, frame_done, error all 0.
  - Skid buffer emptied; frame memory contents are not cleared.
- Storage: single-port-write / single-port-read RAM of TOTAL words, inferred as block RAM, synchronous read with 1-cycle latency.
- States: IDLE -> FILL -> DRAIN -> IDLE.
- IDLE:
  - in_valid ignored.
  - start: clear error and write counters, go to FILL, busy=1 from the next cycle.
- FILL:
  - Each in_valid writes mem[in_channel*P + wr_pix]. wr_pix counts 0..P-1 and wraps to 0 when exp_ch increments.
  - Protocol check: if in_channel != exp_ch, set error; the word is still written at the address computed from the in_channel tag.
  - After the write of word TOTAL-1 (exp_ch = CHANNELS-1, wr_pix = P-1), go to DRAIN on the next cycle.
  - A start pulse during FILL or DRAIN is ignored.
- DRAIN:
  - Read address = rd_ch*P + rd_pix. rd_ch is the inner loop (0..CHANNELS-1); rd_pix is the outer loop (0..P-1).
  - Read pipeline feeds a 2-entry skid buffer. A read is issued only when (skid occupancy + reads in flight) < 2.
  - With out_ready held high, sustained throughput is one word per cycle.
  - First out_valid appears exactly 2 cycles after entering DRAIN.
  - out_valid/out_data/out_channel/out_last stay stable while out_valid=1 and out_ready=0. A word transfers on out_valid & out_ready.
  - in_valid during DRAIN is dropped and sets error.
- Completion:
  - On the cycle out_last transfers: go to IDLE; frame_done=1 on the following cycle for exactly one cycle; busy=0 on that same cycle.
  - out_valid must not be reasserted until the next frame.
- Reset mid-operation: returns to IDLE immediately; a partial frame is discarded; no frame_done is produced.
- Simultaneous events: in the cycle start and in_valid are both high in IDLE, in_valid is ignored; capture begins the following cycle.
- Data is never modified: no arithmetic, saturation or rounding.

Test Plan:
- Small configuration for all scenarios: OUT_SIZE=4, CHANNELS=2 (P=16, TOTAL=32).
- Scenario 1, basic reorder:
  - Stimulus: start; feed ch0 words 0x0000..0x000F, then ch1 words 0x0100..0x010F, in_valid continuous; out_ready=1.
  - Response: output sequence 0x0000,0x0100,0x0001,0x0101,...,0x000F,0x010F with out_channel alternating 0,1.
  - out_last only on 0x010F; frame_done pulses once; error=0.
- Scenario 2, latency and throughput:
  - Stimulus: same frame as scenario 1.
  - Response: first out_valid 2 cycles after DRAIN entry; 32 words in 32 consecutive cycles.
- Scenario 3, backpressure:
  - Stimulus: random out_ready at 30% duty; out_ready=0 for 10 cycles mid-frame.
  - Response: out_data held stable while stalled; sequence identical to scenario 1; no drops or duplicates.
- Scenario 4, protocol error:
  - Stimulus: send word 5 of ch0 tagged in_channel=1; separately, drive in_valid during DRAIN.
  - Response: error=1 and stays high until the next start; drain still completes with 32 words.
- Scenario 5, reset mid-frame:
  - Stimulus: drop rst for 1 cycle after 20 input words.
  - Response: all outputs 0 asynchronously; state IDLE; no frame_done.
  - A subsequent full frame reorders correctly.
- Scenario 6, ignored start and gappy input:
  - Stimulus: pulse start during FILL; insert idle gaps of 3 cycles between input words.
  - Response: capture unaffected; output identical to scenario 1.
